// File: rtl/fbc_sched_pkg.sv
// Shared types and default widths for the conv read-side scheduler.
// State encoding is visible to both the FSM and anything that probes it.
package fbc_sched_pkg;

  localparam int ADDR_W = 13;
  localparam int LANES  = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    COLLECT,
    ADVANCE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sched_addr_gen.sv
// Window address generator: loads the base, steps by STRIDE and wraps back
// to the base when the step would pass the last legal window.
module sched_addr_gen #(
  parameter int ADDR_W = fbc_sched_pkg::ADDR_W,
  parameter int STRIDE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        wrap_count
);

  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        wrap_reg;
  logic [ADDR_W:0]   addr_step_next;
  logic              wrap_hit;

  // One extra bit so a step past the top of the address space still compares as "beyond last".
  assign addr_step_next = {1'b0, addr_reg} + (ADDR_W+1)'(STRIDE);
  assign wrap_hit       = addr_step_next > {1'b0, last};

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
      wrap_reg <= '0;
    end else begin
      if (clear) begin
        wrap_reg <= '0;
      end
      if (load) begin
        addr_reg <= base;
      end else if (step) begin
        if (wrap_hit) begin
          addr_reg <= base;
          if (wrap_reg != 8'hFF) begin
            wrap_reg <= wrap_reg + 8'd1;
          end
        end else begin
          addr_reg <= addr_step_next[ADDR_W-1:0];
        end
      end
    end
  end

  assign rd_addr    = addr_reg;
  assign wrap_count = wrap_reg;

endmodule

// File: rtl/conv_rd_scheduler.sv
// PE-array read scheduler: issues window addresses, counts lane-0 results per burst
// and stops at the programmed target. Define FBC_SCHED_WDOG_EN for the WAIT watchdog.
module conv_rd_scheduler #(
  parameter int ADDR_W      = fbc_sched_pkg::ADDR_W,
  parameter int LANES       = fbc_sched_pkg::LANES,
  parameter int STRIDE      = 16,
  parameter int CNT_W       = fbc_sched_pkg::CNT_W,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic [CNT_W-1:0]  cfg_target,
  input  logic [LANES-1:0]  pe_valid,
  output logic              pe_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  res_count,
  output logic [7:0]        wrap_count
);

  import fbc_sched_pkg::*;

  sched_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, last_reg;
  logic [CNT_W-1:0]  target_reg, res_count_reg, res_count_next;
  logic              pe_en_reg, pe_en_next, busy_reg, busy_next, done_reg, done_next;
  logic              run_start, any_valid, count_hit, count_beat, wdog_fire;
  logic              load_addr, step_addr;

  assign run_start = (state_reg == IDLE) && start;
  assign any_valid = |pe_valid;
  assign count_hit = pe_valid[0] && ((res_count_reg + CNT_W'(1)) == target_reg);

`ifdef FBC_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_reg;
  logic              err_reg;

  assign wdog_fire = (state_reg == WAIT) && !any_valid &&
                     (wdog_reg == WDOG_W'(WDOG_CYCLES - 1));

  // Counter is zero in every other state, so it restarts on each entry to WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      wdog_reg <= (state_reg == WAIT) ? wdog_reg + WDOG_W'(1) : '0;
      if (run_start) begin
        err_reg <= 1'b0;
      end else if (wdog_fire && !abort) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES > 0);
  assign wdog_fire   = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      last_reg      <= '0;
      target_reg    <= '0;
      res_count_reg <= '0;
      pe_en_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      res_count_reg <= res_count_next;
      pe_en_reg     <= pe_en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      if (run_start) begin
        base_reg   <= cfg_base;
        last_reg   <= cfg_last;
        target_reg <= cfg_target;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = LOAD;
        LOAD:    state_next = (target_reg == '0) ? DONE : WAIT;
        WAIT: begin
          // A single-beat target can complete on the very first beat of a burst.
          if (any_valid)      state_next = count_hit ? DONE : COLLECT;
          else if (wdog_fire) state_next = DONE;
        end
        COLLECT: begin
          if (count_hit)       state_next = DONE;
          else if (!any_valid) state_next = ADVANCE;
        end
        ADVANCE: state_next = WAIT;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    count_beat     = pe_valid[0] && !abort && ((state_reg == WAIT) || (state_reg == COLLECT));
    res_count_next = res_count_reg;
    if (run_start) begin
      res_count_next = '0;
    end else if (count_beat) begin
      res_count_next = res_count_reg + CNT_W'(1);
    end
    load_addr  = (state_reg == LOAD) && !abort;
    step_addr  = (state_reg == ADVANCE) && !abort;
    pe_en_next = state_next inside {WAIT, COLLECT, ADVANCE, DONE};
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
  end

  sched_addr_gen #(
    .ADDR_W (ADDR_W),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (run_start),
    .load       (load_addr),
    .step       (step_addr),
    .base       (base_reg),
    .last       (last_reg),
    .rd_addr    (rd_addr),
    .wrap_count (wrap_count)
  );

  assign pe_en     = pe_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign res_count = res_count_reg;

endmodule

// File: tb/tb_conv_rd_scheduler.sv
// Self-checking bench for conv_rd_scheduler: a burst-emitting datapath model plus an
// address scoreboard; the watchdog scenario follows FBC_SCHED_WDOG_EN.
module tb_conv_rd_scheduler;

  localparam int ADDR_W = 13;
  localparam int LANES  = 16;
  localparam int CNT_W  = 16;
  localparam int WDOG   = 32;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_last;
  logic [CNT_W-1:0]  cfg_target;
  logic [LANES-1:0]  pe_valid;
  logic              pe_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  res_count;
  logic [7:0]        wrap_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Datapath model state
  bit                model_on = 1'b0;
  bit                sb_on    = 1'b0;
  logic [LANES-1:0]  model_valid;
  logic [LANES-1:0]  manual_valid = '0;
  logic              prev_en;
  logic [ADDR_W-1:0] prev_addr;
  logic [ADDR_W-1:0] exp_a;
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                dly = 0;
  int                left = 0;
  int                beats_driven = 0;
  int                addr_seen = 0;

  assign pe_valid = model_on ? model_valid : manual_valid;

  conv_rd_scheduler #(
    .ADDR_W      (ADDR_W),
    .LANES       (LANES),
    .STRIDE      (16),
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_base   (cfg_base),
    .cfg_last   (cfg_last),
    .cfg_target (cfg_target),
    .pe_valid   (pe_valid),
    .pe_en      (pe_en),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .res_count  (res_count),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: 9-beat all-lane burst starting 4 cycles after each new address;
  // each new address is popped against the expected-address scoreboard.
  initial begin
    model_valid = '0;
    prev_en     = 1'b0;
    prev_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (model_on && pe_en && (!prev_en || rd_addr != prev_addr)) begin
        addr_seen++;
        $display("[%0t] window rd_addr=0x%03h", $time, rd_addr);
        if (sb_on) begin
          n_checks++;
          if (exp_addr_q.size() == 0) begin
            n_fail++;
            $display("FAIL addr_seq: got rd_addr=0x%03h, required no further address", rd_addr);
          end else begin
            exp_a = exp_addr_q.pop_front();
            if (rd_addr !== exp_a) begin
              n_fail++;
              $display("FAIL addr_seq: got rd_addr=0x%03h, required 0x%03h", rd_addr, exp_a);
            end
          end
        end
        dly  = 4;
        left = 9;
      end
      if (!pe_en || !model_on) begin
        dly  = 0;
        left = 0;
      end
      if (dly > 0) begin
        dly--;
        model_valid = '0;
      end else if (left > 0) begin
        left--;
        model_valid = '1;
        beats_driven++;
      end else begin
        model_valid = '0;
      end
      prev_en   = pe_en;
      prev_addr = rd_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                             input logic [CNT_W-1:0] t);
    cfg_base   = b;
    cfg_last   = l;
    cfg_target = t;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    // Scramble cfg so a design that fails to hold its sampled copy is exposed
    cfg_base   = 13'h1550;
    cfg_last   = 13'h1FF0;
    cfg_target = 16'd3;
  endtask

  task automatic wait_done(input int budget, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic new_run(input bit scoreboard);
    exp_addr_q.delete();
    sb_on        = scoreboard;
    beats_driven = 0;
    addr_seen    = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (pe_en !== 1'b0)      begin n_fail++; $display("FAIL reset_pe_en: got %0b, required 0", pe_en); end
    n_checks++; if (rd_addr !== '0)      begin n_fail++; $display("FAIL reset_rd_addr: got 0x%03h, required 0", rd_addr); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %0b, required 0", done); end
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %0b, required 0", err); end
    n_checks++; if (res_count !== '0)    begin n_fail++; $display("FAIL reset_res_count: got %0d, required 0", res_count); end
    n_checks++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL reset_wrap_count: got %0d, required 0", wrap_count); end
  endtask

  task automatic test_basic_run();
    bit got;
    int cyc;
    new_run(1'b1);
    model_on = 1'b1;
    for (int i = 0; i < 10; i++) exp_addr_q.push_back(ADDR_W'(i * 16));
    pulse_start(13'h000, 13'h0F0, 16'd90);
    wait_done(3000, got, cyc);
    $display("[%0t] basic run: done=%0b res_count=%0d wrap_count=%0d", $time, got, res_count, wrap_count);
    n_checks++; if (!got)                   begin n_fail++; $display("FAIL basic_done: got no done in 3000 cycles, required done"); end
    n_checks++; if (res_count !== 16'd90)   begin n_fail++; $display("FAIL basic_res_count: got %0d, required 90", res_count); end
    n_checks++; if (wrap_count !== 8'd0)    begin n_fail++; $display("FAIL basic_wrap_count: got %0d, required 0", wrap_count); end
    n_checks++; if (rd_addr !== 13'h090)    begin n_fail++; $display("FAIL basic_last_addr: got 0x%03h, required 0x090", rd_addr); end
    n_checks++; if (addr_seen != 10)        begin n_fail++; $display("FAIL basic_addr_count: got %0d, required 10", addr_seen); end
    n_checks++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL basic_addr_left: got %0d pending, required 0", exp_addr_q.size()); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || pe_en !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_done: got done=%0b busy=%0b pe_en=%0b, required 0 0 0", done, busy, pe_en);
    end
    repeat (5) tick();
    n_checks++; if (res_count !== 16'd90)   begin n_fail++; $display("FAIL basic_hold: got %0d, required 90", res_count); end
  endtask

  task automatic test_wrap();
    bit got;
    int cyc;
    new_run(1'b1);
    model_on = 1'b1;
    for (int i = 0; i < 16; i++) exp_addr_q.push_back(ADDR_W'(i * 16));
    for (int i = 0; i < 7; i++)  exp_addr_q.push_back(ADDR_W'(i * 16));
    pulse_start(13'h000, 13'h0F0, 16'd200);
    wait_done(6000, got, cyc);
    $display("[%0t] wrap run: done=%0b res_count=%0d wrap_count=%0d", $time, got, res_count, wrap_count);
    n_checks++; if (!got)                   begin n_fail++; $display("FAIL wrap_done: got no done in 6000 cycles, required done"); end
    n_checks++; if (res_count !== 16'd200)  begin n_fail++; $display("FAIL wrap_res_count: got %0d, required 200", res_count); end
    n_checks++; if (wrap_count !== 8'd1)    begin n_fail++; $display("FAIL wrap_count: got %0d, required 1", wrap_count); end
    n_checks++; if (rd_addr !== 13'h060)    begin n_fail++; $display("FAIL wrap_last_addr: got 0x%03h, required 0x060", rd_addr); end
    n_checks++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL wrap_addr_left: got %0d pending, required 0", exp_addr_q.size()); end
    tick();
  endtask

  task automatic test_zero_target();
    bit got;
    int cyc;
    new_run(1'b1);
    model_on = 1'b1;
    exp_addr_q.push_back(13'h040);
    pulse_start(13'h040, 13'h0F0, 16'd0);
    wait_done(20, got, cyc);
    $display("[%0t] zero-target run: done=%0b cycles=%0d", $time, got, cyc + 1);
    n_checks++; if (!got || cyc != 1)       begin n_fail++; $display("FAIL zero_latency: got done=%0b after %0d cycles, required 2", got, cyc + 1); end
    n_checks++; if (res_count !== '0)       begin n_fail++; $display("FAIL zero_res_count: got %0d, required 0", res_count); end
    n_checks++; if (rd_addr !== 13'h040)    begin n_fail++; $display("FAIL zero_addr: got 0x%03h, required 0x040", rd_addr); end
    repeat (8) tick();
    n_checks++; if (addr_seen != 1 || rd_addr !== 13'h040) begin
      n_fail++; $display("FAIL zero_no_step: got %0d addresses last 0x%03h, required 1 at 0x040", addr_seen, rd_addr);
    end
  endtask

  task automatic test_lane0_low();
    model_on     = 1'b0;
    manual_valid = '0;
    pulse_start(13'h020, 13'h030, 16'd2);
    tick();
    manual_valid = 16'hFFFE;
    tick();
    tick();
    n_checks++; if (res_count !== '0 || rd_addr !== 13'h020 || !busy) begin
      n_fail++; $display("FAIL lane0_low_open: got res=%0d addr=0x%03h busy=%0b, required 0 0x020 1", res_count, rd_addr, busy);
    end
    manual_valid = 16'hFFFF;
    tick();
    n_checks++; if (res_count !== 16'd1)    begin n_fail++; $display("FAIL lane0_count: got %0d, required 1", res_count); end
    manual_valid = '0;
    tick();
    n_checks++; if (rd_addr !== 13'h020)    begin n_fail++; $display("FAIL drain_latency_early: got 0x%03h, required 0x020", rd_addr); end
    tick();
    n_checks++; if (rd_addr !== 13'h030)    begin n_fail++; $display("FAIL drain_latency: got 0x%03h, required 0x030", rd_addr); end
    manual_valid = 16'h0001;
    tick();
    manual_valid = '0;
    $display("[%0t] lane0 run: done=%0b res_count=%0d", $time, done, res_count);
    n_checks++; if (done !== 1'b1 || res_count !== 16'd2) begin
      n_fail++; $display("FAIL lane0_done: got done=%0b res=%0d, required 1 2", done, res_count);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    bit got;
    int cyc;
    new_run(1'b1);
    model_on = 1'b1;
    exp_addr_q.push_back(13'h000);
    exp_addr_q.push_back(13'h010);
    pulse_start(13'h000, 13'h0F0, 16'd18);
    repeat (6) tick();
    pulse_start(13'h200, 13'h2F0, 16'd5);
    wait_done(500, got, cyc);
    $display("[%0t] start-while-busy run: done=%0b res_count=%0d", $time, got, res_count);
    n_checks++; if (!got || res_count !== 16'd18) begin
      n_fail++; $display("FAIL busy_start_res: got done=%0b res=%0d, required 1 18", got, res_count);
    end
    n_checks++; if (rd_addr !== 13'h010 || addr_seen != 2) begin
      n_fail++; $display("FAIL busy_start_addr: got 0x%03h after %0d addresses, required 0x010 after 2", rd_addr, addr_seen);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [CNT_W-1:0] exp_cnt;
    bit               seen;
    bit               saw_done;
    new_run(1'b0);
    model_on = 1'b1;
    pulse_start(13'h100, 13'h1F0, 16'd90);
    n_checks++; if (busy !== 1'b1 || pe_en !== 1'b0) begin
      n_fail++; $display("FAIL start_latency_1: got busy=%0b pe_en=%0b, required 1 0", busy, pe_en);
    end
    tick();
    n_checks++; if (pe_en !== 1'b1 || rd_addr !== 13'h100) begin
      n_fail++; $display("FAIL start_latency_2: got pe_en=%0b addr=0x%03h, required 1 0x100", pe_en, rd_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pe_valid != '0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_burst: got no burst in 50 cycles, required burst"); end
    tick();
    tick();
    abort   = 1'b1;
    exp_cnt = CNT_W'(beats_driven - (pe_valid[0] ? 1 : 0));
    tick();
    abort = 1'b0;
    $display("[%0t] abort: res_count=%0d busy=%0b", $time, res_count, busy);
    n_checks++; if (busy !== 1'b0 || pe_en !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%0b pe_en=%0b done=%0b, required 0 0 0", busy, pe_en, done);
    end
    n_checks++; if (res_count !== exp_cnt)  begin n_fail++; $display("FAIL abort_res_count: got %0d, required %0d", res_count, exp_cnt); end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done || res_count !== exp_cnt) begin
      n_fail++; $display("FAIL abort_frozen: got done_seen=%0b res=%0d, required 0 %0d", saw_done, res_count, exp_cnt);
    end
  endtask

  task automatic test_wait_watchdog();
    model_on     = 1'b0;
    manual_valid = '0;
`ifdef FBC_SCHED_WDOG_EN
    begin
      bit got;
      int cyc;
      pulse_start(13'h040, 13'h0F0, 16'd5);
      tick();
      wait_done(200, got, cyc);
      $display("[%0t] watchdog: done=%0b err=%0b cycles=%0d", $time, got, err, cyc);
      n_checks++; if (!got || cyc != WDOG)   begin n_fail++; $display("FAIL wdog_latency: got done=%0b after %0d cycles, required %0d", got, cyc, WDOG); end
      n_checks++; if (err !== 1'b1)          begin n_fail++; $display("FAIL wdog_err: got %0b, required 1", err); end
      tick();
      n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL wdog_sticky: got err=%0b busy=%0b, required 1 0", err, busy);
      end
      pulse_start(13'h040, 13'h0F0, 16'd5);
      n_checks++; if (err !== 1'b0)          begin n_fail++; $display("FAIL wdog_clear: got %0b, required 0", err); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
`else
    begin
      bit saw_done;
      pulse_start(13'h040, 13'h0F0, 16'd5);
      saw_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (done) saw_done = 1'b1;
      end
      $display("[%0t] wait hold: busy=%0b err=%0b", $time, busy, err);
      n_checks++; if (saw_done || busy !== 1'b1 || err !== 1'b0) begin
        n_fail++; $display("FAIL wait_blocks: got done_seen=%0b busy=%0b err=%0b, required 0 1 0", saw_done, busy, err);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL wait_abort: got busy=%0b, required 0", busy); end
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    model_on     = 1'b0;
    manual_valid = '0;
    pulse_start(13'h300, 13'h3F0, 16'd10);
    tick();
    tick();
    n_checks++; if (busy !== 1'b1 || rd_addr !== 13'h300) begin
      n_fail++; $display("FAIL midwait_setup: got busy=%0b addr=0x%03h, required 1 0x300", busy, rd_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("[%0t] reset mid-wait: busy=%0b rd_addr=0x%03h", $time, busy, rd_addr);
    n_checks++; if (pe_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midwait_reset_flags: got pe_en=%0b busy=%0b done=%0b err=%0b, required 0 0 0 0", pe_en, busy, done, err);
    end
    n_checks++; if (rd_addr !== '0 || res_count !== '0 || wrap_count !== 8'd0) begin
      n_fail++; $display("FAIL midwait_reset_vals: got addr=0x%03h res=%0d wrap=%0d, required 0 0 0", rd_addr, res_count, wrap_count);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_base   = '0;
    cfg_last   = '0;
    cfg_target = '0;
    test_reset();
    test_basic_run();
    test_wrap();
    test_zero_target();
    test_lane0_low();
    test_start_while_busy();
    test_abort();
    test_wait_watchdog();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_rd_scheduler.md
Name: conv_rd_scheduler

Overview:
- Sequences the PE-array read side of the fused conv datapath.
- Issues `rd_addr` window addresses to the BRAM/PE top level and drives its `en` input.
- Watches the 16-lane `valid_out` bursts. Advances to the next window once the current burst has drained. Wraps the address across the feature-map row range. Stops after a programmed number of lane-0 results.
- Replaces bench-side address stepping; sits between the layer control logic and the datapath top.

Parameters:
- ADDR_W, 13, read address width (matches datapath `rd_addr`)
- LANES, 16, PE output lanes / width of `pe_valid`
- STRIDE, 16, address increment per window
- CNT_W, 16, width of result counter and target
- WDOG_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (ignored unless IDLE)
- abort  in  1  terminates a run; returns to IDLE next cycle, no `done`
- cfg_base  in  ADDR_W  first window address, also the wrap target
- cfg_last  in  ADDR_W  highest legal window address
- cfg_target  in  CNT_W  number of lane-0 valid beats to collect
- pe_valid  in  LANES  datapath `valid_out`
- pe_en  out  1  datapath enable
- rd_addr  out  ADDR_W  datapath read address
- busy  out  1  high from LOAD through DONE inclusive
- done  out  1  one-cycle pulse at end of run
- err  out  1  watchdog expiry flag, sticky until next start
- res_count  out  CNT_W  lane-0 valid beats so far
- wrap_count  out  8  number of address wraps this run (saturates at 255)

Behaviour:
- Reset values:
  - state = IDLE
  - `pe_en` = 0, `rd_addr` = 0, `busy` = 0, `done` = 0, `err` = 0
  - `res_count` = 0, `wrap_count` = 0
- All outputs are registered.
- IDLE:
  - On `start`, go to LOAD.
  - `cfg_*` are sampled in that same cycle and held internally for the whole run.
  - `res_count`, `wrap_count` and `err` clear on this transition.
- LOAD:
  - `rd_addr` <= `cfg_base`; `pe_en` <= 1.
  - If `cfg_target` == 0, go to DONE. Otherwise go to WAIT.
- WAIT:
  - Hold `rd_addr`.
  - When `pe_valid` != 0, go to COLLECT. That cycle's lane-0 beat is counted.
- COLLECT:
  - Every cycle with `pe_valid[0]` = 1, `res_count` increments.
  - If the increment makes `res_count` == `cfg_target`, go to DONE immediately, even if other lanes are still valid.
  - Otherwise, when `pe_valid` == 0, go to ADVANCE.
- ADVANCE (exactly one cycle):
  - next = `rd_addr` + STRIDE, computed at ADDR_W+1 bits.
  - If next > `cfg_last`: `rd_addr` <= `cfg_base` and `wrap_count` increments (saturating).
  - Otherwise `rd_addr` <= next[ADDR_W-1:0].
  - Then go to WAIT.
- DONE (one cycle):
  - `done` = 1 and `pe_en` <= 0; then go to IDLE.
  - `rd_addr` and the counters hold their values until the next start.
- `abort` in any non-IDLE state:
  - Next state IDLE, `pe_en` <= 0, no `done` pulse, counters hold.
  - `abort` takes priority over every other transition in the same cycle.
- `start` while busy: ignored. `start` and `abort` together in IDLE: `start` wins.
- `reset` mid-run: all state and outputs return to reset values on the next edge.
- `pe_valid` with lane 0 low but other lanes high: the beat is not counted but the burst stays open.
- Latency:
  - `start` to first `rd_addr` = `cfg_base` with `pe_en` = 1: 2 cycles.
  - Burst drain (`pe_valid` = 0 seen) to new `rd_addr`: 2 cycles.

Optional Feature:
- Macro: FBC_SCHED_WDOG_EN
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - Reaching WDOG_CYCLES with no valid beat sets `err`. The block then goes to DONE, so `done` pulses with `err` = 1.
- Undefined:
  - No counter; WAIT blocks indefinitely.
  - `err` is tied to 0.

Decomposition:
- Package `fbc_sched_pkg`:
  - State enum `sched_state_t` {IDLE, LOAD, WAIT, COLLECT, ADVANCE, DONE}
  - Default constants ADDR_W, LANES, CNT_W
- Sub-module `sched_addr_gen`:
  - Holds `rd_addr`, performs load-base / step / wrap, and produces `wrap_count`.
  - Controlled by load/step strobes from the FSM.

Test Plan:
- Basic run:
  - Stimulus: `cfg_base` 0x000, `cfg_last` 0x0F0, `cfg_target` 90; datapath model emits a 9-beat all-lanes burst 4 cycles after each address.
  - Response: `rd_addr` steps 0x000, 0x010, … 0x090; `done` on the 90th lane-0 beat; `res_count` = 90, `wrap_count` = 0.
- Wrap:
  - Stimulus: `cfg_target` 200, otherwise as Basic run.
  - Response: after 0x0F0 the next address is 0x000; `wrap_count` = 1 at done.
- Zero target:
  - Stimulus: `cfg_target` 0.
  - Response: `done` 2 cycles after `start`; no address beyond `cfg_base`; `res_count` = 0.
- Abort mid-COLLECT:
  - Stimulus: assert `abort` during a COLLECT burst.
  - Response: IDLE next cycle, `pe_en` = 0, no `done`, `res_count` frozen.
- Reset and start-while-busy:
  - Stimulus: `start` while busy.
  - Response: no effect.
  - Stimulus: `reset` mid-WAIT.
  - Response: all outputs equal reset values on the next cycle.
- Watchdog (FBC_SCHED_WDOG_EN defined, WDOG_CYCLES = 32):
  - Stimulus: `pe_valid` held at 0.
  - Response: `done` with `err` = 1 after 32 WAIT cycles.
